car_parking_exit_gate: RTL

//   Exit-side controller for the smart car parking system. It is the counterpart of the entrance password gate.
//   - Verifies a 4-bit exit code from a departing car, then opens the exit barrier.
//   - Confirms the car has passed, then releases one occupancy slot.
//   - Owns the occupancy counter: increments on admissions reported by the entrance controller, decrements on confirmed exits.

---
 rtl/car_parking_exit_gate_if.sv | 29 ++
 rtl/car_parking_exit_gate.sv | 126 ++++++++++++
 2 files changed

// File: rtl/car_parking_exit_gate_if.sv
// Exit-gate signal bundle: driver-side sensors/keypad/entrance pulse in, gate status out.
interface car_parking_exit_gate_if #(
  parameter int unsigned CNT_W  = 4,
  parameter int unsigned PASS_W = 4
);
  logic              Exit;
  logic              Exit_Clear;
  logic              Code_Valid;
  logic [PASS_W-1:0] Code;
  logic              Car_Entered;
  logic              Green;
  logic              Red;
  logic              Gate_Open;
  logic              Alarm;
  logic [CNT_W-1:0]  Count_CAR;
  logic              Full;
  logic              Empty;
  logic [2:0]        INDICATOR;

  modport master (
    output Exit, Exit_Clear, Code_Valid, Code, Car_Entered,
    input  Green, Red, Gate_Open, Alarm, Count_CAR, Full, Empty, INDICATOR
  );

  modport slave (
    input  Exit, Exit_Clear, Code_Valid, Code, Car_Entered,
    output Green, Red, Gate_Open, Alarm, Count_CAR, Full, Empty, INDICATOR
  );
endinterface

// File: rtl/car_parking_exit_gate.sv
// Exit-side parking controller: checks the exit code, opens the barrier, and owns
// the occupancy counter fed by entrance admissions and confirmed exits.
module car_parking_exit_gate #(
  parameter int unsigned       MAX_CARS     = 9,
  parameter int unsigned       CNT_W        = 4,
  parameter int unsigned       PASS_W       = 4,
  parameter logic [PASS_W-1:0] EXIT_CODE    = 4'b1010,
  parameter int unsigned       MAX_TRIES    = 3,
  parameter int unsigned       GATE_TIMEOUT = 8
) (
  input logic                    CLOCK,
  input logic                    RESET,
  car_parking_exit_gate_if.slave bus
);

  localparam int unsigned TRIES_W = $clog2(MAX_TRIES + 1);
  localparam int unsigned TMR_W   = (GATE_TIMEOUT > 1) ? $clog2(GATE_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    IDLE      = 3'b000,
    WAIT_CODE = 3'b001,
    BAD_CODE  = 3'b010,
    OPEN      = 3'b011,
    LOCKOUT   = 3'b100
  } state_e;

  state_e             state_q, state_d;
  logic [TRIES_W-1:0] tries_q, tries_d, tries_inc;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               green_q, green_d;
  logic               red_q, red_d;
  logic               gate_q, gate_d;
  logic               alarm_q, alarm_d;
  logic               exit_evt;
  logic               full_c, empty_c;

  assign full_c    = (count_q == CNT_W'(MAX_CARS));
  assign empty_c   = (count_q == '0);
  assign tries_inc = tries_q + TRIES_W'(1);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q <= IDLE;
      tries_q <= '0;
      timer_q <= '0;
      count_q <= '0;
      green_q <= 1'b0;
      red_q   <= 1'b0;
      gate_q  <= 1'b0;
      alarm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      timer_q <= timer_d;
      count_q <= count_d;
      green_q <= green_d;
      red_q   <= red_d;
      gate_q  <= gate_d;
      alarm_q <= alarm_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    tries_d  = tries_q;
    timer_d  = '0;
    count_d  = count_q;
    exit_evt = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Exit && !empty_c) state_d = WAIT_CODE;
      end
      WAIT_CODE, BAD_CODE: begin
        // A code strobe wins over the car leaving the sensor in the same cycle
        if (bus.Code_Valid) begin
          if (bus.Code == EXIT_CODE) begin
            state_d = OPEN;
          end else begin
            tries_d = tries_inc;
            state_d = (tries_inc == TRIES_W'(MAX_TRIES)) ? LOCKOUT : BAD_CODE;
          end
        end else if (!bus.Exit) begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        if (bus.Exit_Clear) begin
          exit_evt = 1'b1;
          state_d  = IDLE;
        end else if (timer_q == TMR_W'(GATE_TIMEOUT - 1)) begin
          state_d = IDLE;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      LOCKOUT: ;
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) tries_d = '0;

    // Simultaneous admission and exit cancel out
    unique case ({bus.Car_Entered, exit_evt})
      2'b10:   if (!full_c)  count_d = count_q + CNT_W'(1);
      2'b01:   if (!empty_c) count_d = count_q - CNT_W'(1);
      default: ;
    endcase

    green_d = (state_d == OPEN);
    gate_d  = (state_d == OPEN);
    red_d   = (state_d == BAD_CODE) || (state_d == LOCKOUT);
    alarm_d = (state_d == LOCKOUT);
  end

  assign bus.Green     = green_q;
  assign bus.Red       = red_q;
  assign bus.Gate_Open = gate_q;
  assign bus.Alarm     = alarm_q;
  assign bus.Count_CAR = count_q;
  assign bus.Full      = full_c;
  assign bus.Empty     = empty_c;
  assign bus.INDICATOR = state_q;

endmodule
